// File: rtl/wb_core_master_pkg.sv
// Shared types and constants for the Wishbone core-side master.
package wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP
  } wb_mst_state_e;

  localparam int unsigned WB_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/wb_core_master_if.sv
// Pipelined Wishbone B4 bus bundle; clock and reset are shared with the attached blocks.
interface wishbone_if (
  input logic clk,
  input logic rst_n
);
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] addr;
  logic [31:0] data_m;
  logic [31:0] data_s;
  logic        ack;
  logic        err;
  logic        stall;

  modport master (
    input  clk, rst_n,
    output cyc, stb, we, sel, addr, data_m,
    input  data_s, ack, err, stall
  );

  modport slave (
    input  clk, rst_n,
    input  cyc, stb, we, sel, addr, data_m,
    output data_s, ack, err, stall
  );
endinterface

// File: rtl/wb_core_master_timeout.sv
// Access watchdog: counts cycles while enabled, flags the cycle that reaches the limit.
module wb_timeout_ctr
  import wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = WB_TIMEOUT_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + W'(1);
    end
  end

  // Asserted during the cycle whose increment would reach the limit, so the
  // abort edge lands exactly TIMEOUT_CYCLES edges after the clearing edge.
  always_comb begin
    expired = enable && (cnt == W'(TIMEOUT_CYCLES - 1));
  end

endmodule

// File: rtl/wb_core_master.sv
// Core data-port to pipelined Wishbone bridge; one outstanding access with watchdog abort.
module wb_core_master
  import wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = WB_TIMEOUT_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  wishbone_if.master  wb
);

  wb_mst_state_e state;
  logic          grant;
  logic          active;
  logic          rsp_seen;
  logic          expired;

  always_comb begin
    grant    = data_req_i && ((state == ST_IDLE) || (state == ST_RESP));
    active   = (state == ST_REQ) || (state == ST_WAIT);
    // A response only counts once the strobe is accepted or already past.
    rsp_seen = (wb.ack || wb.err) &&
               (((state == ST_REQ) && !wb.stall) || (state == ST_WAIT));
  end

  assign data_gnt_o = grant;

  wb_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear   (grant),
    .enable  (active),
    .expired (expired)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= ST_IDLE;
      wb.cyc        <= 1'b0;
      wb.stb        <= 1'b0;
      wb.we         <= 1'b0;
      wb.sel        <= '0;
      wb.addr       <= '0;
      wb.data_m     <= '0;
      data_rvalid_o <= 1'b0;
      data_rdata_o  <= '0;
      data_err_o    <= 1'b0;
    end else begin
      data_rvalid_o <= 1'b0;
      case (state)
        ST_IDLE, ST_RESP: begin
          if (grant) begin
            state     <= ST_REQ;
            wb.cyc    <= 1'b1;
            wb.stb    <= 1'b1;
            wb.we     <= data_we_i;
            wb.sel    <= data_be_i;
            wb.addr   <= data_addr_i;
            wb.data_m <= data_wdata_i;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_REQ, ST_WAIT: begin
          if (rsp_seen) begin
            state         <= ST_RESP;
            wb.cyc        <= 1'b0;
            wb.stb        <= 1'b0;
            data_rvalid_o <= 1'b1;
            data_err_o    <= wb.err;
            data_rdata_o  <= wb.we ? '0 : wb.data_s;
          end else if (expired) begin
            state         <= ST_RESP;
            wb.cyc        <= 1'b0;
            wb.stb        <= 1'b0;
            data_rvalid_o <= 1'b1;
            data_err_o    <= 1'b1;
            data_rdata_o  <= '0;
          end else if ((state == ST_REQ) && !wb.stall) begin
            state  <= ST_WAIT;
            wb.stb <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_core_master.sv
// Directed and randomized bench for wb_core_master with a scripted Wishbone slave.
module tb_wb_core_master;

  localparam int unsigned TMO = 8;

  logic        clk_i  = 1'b0;
  logic        rst_ni = 1'b1;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err_o;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Current transaction description and the slave's scripted behaviour.
  logic        t_we;
  logic [3:0]  t_be;
  logic [31:0] t_addr;
  logic [31:0] t_wdata;
  logic [31:0] t_sdata;
  int unsigned t_stall;
  int unsigned t_dly;
  logic        t_ack;
  logic        t_err;

  // Expected response of the transaction in flight.
  logic [31:0] e_rdata;
  logic        e_err;
  int unsigned e_done;

  wishbone_if wbif (.clk(clk_i), .rst_n(rst_ni));

  wb_core_master #(
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .data_req_i    (req),
    .data_we_i     (we),
    .data_be_i     (be),
    .data_addr_i   (addr),
    .data_wdata_i  (wdata),
    .data_gnt_o    (gnt),
    .data_rvalid_o (rvalid),
    .data_rdata_o  (rdata),
    .data_err_o    (err_o),
    .wb            (wbif.master)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle_begin();
    @(posedge wbif.clk);
    #1;
  endtask

  task automatic cycle_sample();
    @(negedge wbif.clk);
  endtask

  // Slave noise while no access is outstanding: responses here must be ignored.
  task automatic slave_idle();
    wbif.ack    = 1'($urandom_range(0, 1));
    wbif.err    = 1'($urandom_range(0, 1));
    wbif.stall  = 1'($urandom_range(0, 1));
    wbif.data_s = $urandom;
  endtask

  task automatic drive_req();
    req   = 1'b1;
    we    = t_we;
    be    = t_be;
    addr  = t_addr;
    wdata = t_wdata;
  endtask

  task automatic drive_noise(input logic r);
    req   = r;
    we    = 1'($urandom_range(0, 1));
    be    = 4'($urandom);
    addr  = $urandom;
    wdata = $urandom;
  endtask

  task automatic set_txn(input logic w, input logic [3:0] b, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] sd,
                         input int unsigned st, input int unsigned dl,
                         input logic ak, input logic er);
    t_we = w; t_be = b; t_addr = a; t_wdata = wd; t_sdata = sd;
    t_stall = st; t_dly = dl; t_ack = ak; t_err = er;
  endtask

  task automatic rand_txn();
    int unsigned kind;
    kind = $urandom_range(0, 7);
    set_txn(1'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom, $urandom,
            $urandom_range(0, 4), $urandom_range(0, 4),
            (kind >= 1 && kind <= 5) || kind == 7, kind >= 6);
  endtask

  // Grant cycle (optional, skipped when granted in the previous RESP) plus all
  // bus cycles up to, but not including, the response cycle.
  task automatic run_txn(input bit first);
    int unsigned a;
    int unsigned k;
    a = 1 + t_stall;
    k = (t_ack || t_err) ? a + t_dly : 32'hFFFF;
    if (k > TMO) begin
      e_done  = TMO + 1;
      e_err   = 1'b1;
      e_rdata = '0;
    end else begin
      e_done  = k + 1;
      e_err   = t_err;
      e_rdata = t_we ? '0 : t_sdata;
    end
    if (first) begin
      cycle_begin();
      drive_req();
      slave_idle();
      cycle_sample();
      chk("gnt_idle", 32'(gnt), 32'd1);
      chk("cyc_before_req", 32'(wbif.cyc), 32'd0);
    end
    for (int unsigned c = 1; c < e_done; c++) begin
      cycle_begin();
      drive_noise(1'($urandom_range(0, 1)));
      wbif.stall  = (c < a);
      wbif.ack    = t_ack && (c == k) && wbif.rst_n;
      wbif.err    = t_err && (c == k) && wbif.rst_n;
      wbif.data_s = (c == k) ? t_sdata : $urandom;
      cycle_sample();
      chk("gnt_busy", 32'(gnt), 32'd0);
      chk("rvalid_busy", 32'(rvalid), 32'd0);
      chk("cyc_busy", 32'(wbif.cyc), 32'd1);
      chk("stb_busy", 32'(wbif.stb), 32'(c <= a));
      chk("addr_hold", wbif.addr, t_addr);
      chk("sel_hold", 32'(wbif.sel), 32'(t_be));
      chk("we_hold", 32'(wbif.we), 32'(t_we));
      chk("data_m_hold", wbif.data_m, t_wdata);
    end
  endtask

  // Response cycle; optionally presents the next request (already in t_*).
  task automatic finish(input bit has_next);
    cycle_begin();
    slave_idle();
    if (has_next) drive_req();
    else drive_noise(1'b0);
    cycle_sample();
    chk("rvalid_resp", 32'(rvalid), 32'd1);
    chk("rdata_resp", rdata, e_rdata);
    chk("err_resp", 32'(err_o), 32'(e_err));
    chk("cyc_resp", 32'(wbif.cyc), 32'd0);
    chk("stb_resp", 32'(wbif.stb), 32'd0);
    chk("gnt_resp", 32'(gnt), 32'(has_next));
  endtask

  task automatic idle_cycle();
    cycle_begin();
    slave_idle();
    drive_noise(1'b0);
    cycle_sample();
    chk("rvalid_idle", 32'(rvalid), 32'd0);
    chk("cyc_idle", 32'(wbif.cyc), 32'd0);
    chk("gnt_idle_noreq", 32'(gnt), 32'd0);
  endtask

  initial begin
    req = 1'b0; we = 1'b0; be = '0; addr = '0; wdata = '0;
    wbif.ack = 1'b0; wbif.err = 1'b0; wbif.stall = 1'b0; wbif.data_s = '0;

    #1 rst_ni = 1'b0;
    #2;
    chk("rst_cyc", 32'(wbif.cyc), 32'd0);
    chk("rst_stb", 32'(wbif.stb), 32'd0);
    chk("rst_we", 32'(wbif.we), 32'd0);
    chk("rst_sel", 32'(wbif.sel), 32'd0);
    chk("rst_addr", wbif.addr, 32'd0);
    chk("rst_data_m", wbif.data_m, 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i) rst_ni = 1'b1;
    idle_cycle();

    // Basic read, ack one cycle after the strobe.
    set_txn(1'b0, 4'hF, 32'h0000_0000, 32'h0, 32'h0000_0005, 0, 1, 1'b1, 1'b0);
    run_txn(1'b1); finish(1'b0); idle_cycle();

    // Write with three stalled cycles.
    set_txn(1'b1, 4'hF, 32'h0000_0100, 32'h0000_000A, 32'hDEAD_BEEF, 3, 1, 1'b1, 1'b0);
    run_txn(1'b1); finish(1'b0); idle_cycle();

    // ack and err together behave as an error.
    set_txn(1'b0, 4'h3, 32'h0000_0200, 32'h0, 32'h0000_1234, 0, 1, 1'b1, 1'b1);
    run_txn(1'b1); finish(1'b0); idle_cycle();

    // Silent slave trips the watchdog.
    set_txn(1'b0, 4'hC, 32'h0000_0300, 32'h0, 32'h5555_5555, 0, 0, 1'b0, 1'b0);
    run_txn(1'b1); finish(1'b0); idle_cycle();

    // Two reads back to back.
    set_txn(1'b0, 4'hF, 32'h0000_0400, 32'h0, 32'h1111_1111, 0, 1, 1'b1, 1'b0);
    run_txn(1'b1);
    set_txn(1'b0, 4'hF, 32'h0000_0404, 32'h0, 32'h2222_2222, 0, 1, 1'b1, 1'b0);
    finish(1'b1);
    run_txn(1'b0); finish(1'b0); idle_cycle();

    // Reset while waiting for the slave.
    set_txn(1'b0, 4'hF, 32'h0000_0500, 32'h0, 32'h7777_7777, 0, 5, 1'b1, 1'b0);
    cycle_begin(); drive_req(); wbif.ack = 1'b0; wbif.err = 1'b0; wbif.stall = 1'b0;
    cycle_sample();
    cycle_begin(); drive_noise(1'b0); cycle_sample();
    chk("rstw_stb_req", 32'(wbif.stb), 32'd1);
    cycle_begin(); cycle_sample();
    chk("rstw_cyc_wait", 32'(wbif.cyc), 32'd1);
    chk("rstw_stb_wait", 32'(wbif.stb), 32'd0);
    #2 rst_ni = 1'b0;
    #1;
    chk("rstw_cyc_async", 32'(wbif.cyc), 32'd0);
    chk("rstw_stb_async", 32'(wbif.stb), 32'd0);
    chk("rstw_addr_async", wbif.addr, 32'd0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i) rst_ni = 1'b1;
    repeat (4) idle_cycle();
    set_txn(1'b0, 4'hF, 32'h0000_0600, 32'h0, 32'h0BAD_F00D, 1, 0, 1'b1, 1'b0);
    run_txn(1'b1); finish(1'b0); idle_cycle();

    // Randomized traffic, randomly chained or separated by idle gaps.
    rand_txn();
    run_txn(1'b1);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        rand_txn();
        finish(1'b1);
        run_txn(1'b0);
      end else begin
        finish(1'b0);
        repeat ($urandom_range(0, 2)) idle_cycle();
        rand_txn();
        run_txn(1'b1);
      end
    end
    finish(1'b0);
    idle_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_core_master.md
WB_CORE_MASTER -- requirements
Module: wb_core_master

Interface
REQ-001 The block SHALL have exactly one clock, clk_i, and an asynchronous active-low reset, rst_ni; both are shared with the attached wishbone_if instance.
REQ-002 Parameter TIMEOUT_CYCLES, default 255, SHALL give the maximum cycles from strobe assertion to ack/err before the block aborts the access.
REQ-003 clk_i  input  1  system clock; all state updates on its rising edge.
REQ-004 rst_ni  input  1  asynchronous active-low reset.
REQ-005 data_req_i  input  1  core requests an access.
REQ-006 data_we_i  input  1  1 = write, 0 = read.
REQ-007 data_be_i  input  4  byte enables.
REQ-008 data_addr_i  input  32  byte address.
REQ-009 data_wdata_i  input  32  write data.
REQ-010 data_gnt_o  output  1  request accepted this cycle.
REQ-011 data_rvalid_o  output  1  one-cycle response strobe.
REQ-012 data_rdata_o  output  32  read data, valid with data_rvalid_o.
REQ-013 data_err_o  output  1  bus error or timeout, valid with data_rvalid_o.
REQ-014 wb  wishbone_if.master  --  pipelined Wishbone B4 initiator: drives cyc, stb, we, sel[3:0], addr, data_m; samples data_s, ack, err, stall.

Function
REQ-015 The FSM SHALL have states IDLE, REQ (cyc=1, stb=1), WAIT (cyc=1, stb=0) and RESP; there SHALL be at most one outstanding access.
REQ-016 In IDLE or RESP, data_gnt_o SHALL equal data_req_i combinationally; on a grant, addr, we, be and wdata SHALL be registered and the FSM SHALL enter REQ.
REQ-017 wb.addr, wb.we, wb.sel and wb.data_m SHALL hold the registered values from REQ entry until return to IDLE/RESP.
REQ-018 In REQ with wb.stall=0, the strobe is accepted: next state WAIT; with wb.stall=1, the FSM SHALL remain in REQ with stb held.
REQ-019 wb.ack or wb.err sampled high in REQ (stall=0) or WAIT SHALL complete the access: next state RESP, cyc=0 and stb=0 from that edge.
REQ-020 RESP SHALL last one cycle with data_rvalid_o=1, data_err_o=registered wb.err, and data_rdata_o=registered wb.data_s for reads or 0 for writes; if no new grant occurs in RESP, the FSM returns to IDLE.
REQ-021 Latency with a zero-stall slave acking one cycle after the strobe: gnt at cycle 0, stb at cycle 1, ack at cycle 2, rvalid at cycle 3; back-to-back grants in RESP SHALL be supported.
REQ-022 A timeout counter SHALL clear on REQ entry and increment each cycle in REQ/WAIT; reaching TIMEOUT_CYCLES without ack/err SHALL force RESP with data_err_o=1, data_rdata_o=0 and cyc dropped.
REQ-023 ack and err asserted together SHALL be treated as err; ack/err outside REQ/WAIT SHALL be ignored.
REQ-024 data_gnt_o SHALL be 0 in REQ and WAIT regardless of data_req_i.

Reset
REQ-025 On rst_ni low, asynchronously: state=IDLE, wb.cyc=0, wb.stb=0, wb.we=0, wb.sel=0, wb.addr=0, wb.data_m=0, data_rvalid_o=0, data_rdata_o=0, data_err_o=0, timeout counter=0.
REQ-026 Reset asserted mid-access SHALL abandon the access with no response strobe after release.

Structure
REQ-027 Package wb_pkg SHALL hold the FSM state enum (wb_mst_state_e) and the default timeout constant WB_TIMEOUT_DEFAULT=255.
REQ-028 The timeout counter SHALL be a sub-module wb_timeout_ctr (inputs clear, enable; output expired), width clog2(TIMEOUT_CYCLES+1).

Verification
REQ-029 Read: req addr=0x0000_0000, slave acks 1 cycle after stb with data_s=0x0000_0005 -> gnt at cycle 0, stb cycles 1 only, rvalid at cycle 3 with rdata=0x5, err=0.
REQ-030 Write: wdata=0xA, be=0xF, stall=1 for 3 cycles -> stb held 4 cycles with data_m=0xA and sel=0xF constant, then one rvalid with rdata=0, err=0.
REQ-031 Error: slave asserts ack and err together -> rvalid with err=1, cyc low the following cycle.
REQ-032 Timeout: TIMEOUT_CYCLES=8, slave never acks -> cyc drops and rvalid with err=1 exactly 8 cycles after REQ entry.
REQ-033 Back-to-back: req held high across two reads -> second gnt coincides with first rvalid; no idle cycle between the two accesses.
REQ-034 Reset mid-WAIT: rst_ni low for 2 cycles -> cyc/stb immediately 0, no rvalid after release, the next request completes normally.
